// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: sequences the PLL reset, qualifies the synchronized extlock,
// and releases the system reset only after a stable lock. Runs entirely on refclk.
module pll_lock_supervisor #(
  parameter int unsigned PLL_RST_CYCLES = 24,
  parameter int unsigned LOCK_TIMEOUT   = 24000,
  parameter int unsigned LOCK_STABLE    = 240,
  parameter int unsigned RETRY_W        = 4
) (
  input  logic               refclk,
  input  logic               reset,
  input  logic               extlock,
  output logic               pll_reset,
  output logic               sys_rst,
  output logic               locked_ok,
  output logic [RETRY_W-1:0] retry_cnt,
  output logic [1:0]         state
);

  localparam int unsigned CNT_MAX_A = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
  localparam int unsigned CNT_MAX   = (CNT_MAX_A > LOCK_STABLE) ? CNT_MAX_A : LOCK_STABLE;
  localparam int unsigned CNT_W     = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {
    S_PLLRST    = 2'd0,
    S_WAIT_LOCK = 2'd1,
    S_STABLE    = 2'd2,
    S_RUN       = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic               sync1_q, sync1_d;
  logic               lock_s_q, lock_s_d;
  logic               pll_reset_q, pll_reset_d;
  logic               sys_rst_q, sys_rst_d;
  logic               locked_ok_q, locked_ok_d;
  logic               retry_inc;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CNT_W'(1);
    retry_inc = 1'b0;
    sync1_d   = extlock;
    lock_s_d  = sync1_q;

    case (state_q)
      S_PLLRST: begin
        if (cnt_q == CNT_W'(PLL_RST_CYCLES - 1)) state_d = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        // A lock seen on the timeout cycle takes priority over the retry.
        if (lock_s_q) begin
          state_d = S_STABLE;
        end else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
          state_d   = S_PLLRST;
          retry_inc = 1'b1;
        end
      end
      S_STABLE: begin
        if (!lock_s_q) begin
          state_d = S_WAIT_LOCK;
        end else if (cnt_q == CNT_W'(LOCK_STABLE - 1)) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        cnt_d = cnt_q;
        if (!lock_s_q) begin
          state_d   = S_PLLRST;
          retry_inc = 1'b1;
        end
      end
      default: state_d = S_PLLRST;
    endcase

    if (state_d != state_q) cnt_d = '0;

    retry_d = retry_q;
    if (retry_inc && (retry_q != '1)) retry_d = retry_q + RETRY_W'(1);

    // Outputs are decoded from the next state so they move on the transition edge.
    pll_reset_d = (state_d == S_PLLRST);
    sys_rst_d   = (state_d != S_RUN);
    locked_ok_d = (state_d == S_RUN);
  end

  always_ff @(posedge refclk) begin
    if (reset) begin
      state_q     <= S_PLLRST;
      cnt_q       <= '0;
      retry_q     <= '0;
      sync1_q     <= 1'b0;
      lock_s_q    <= 1'b0;
      pll_reset_q <= 1'b1;
      sys_rst_q   <= 1'b1;
      locked_ok_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      sync1_q     <= sync1_d;
      lock_s_q    <= lock_s_d;
      pll_reset_q <= pll_reset_d;
      sys_rst_q   <= sys_rst_d;
      locked_ok_q <= locked_ok_d;
    end
  end

  assign pll_reset = pll_reset_q;
  assign sys_rst   = sys_rst_q;
  assign locked_ok = locked_ok_q;
  assign retry_cnt = retry_q;
  assign state     = state_q;

endmodule
